shift_add_ctrl: RTL
===================

# shift_add_ctrl

Control unit of the shift-add multiplier. Sequences the `Load`, `Ad` and `Sh` strobes of the 2N+1-bit accumulator register so that an N-bit multiplier held in the accumulator's low bits is multiplied by the multiplicand. It sits directly upstream of the accumulator and reads back the accumulator's bit 0 (`M`). It reports completion to the surrounding logic with a `Done` output.

## Interface
- `N`, default 4: multiplier width, which is also the number of add/shift iterations; must be ≥ 2.
- `Clk`  in  1: single clock; all state changes on the rising edge.
- `Rst_n`  in  1: asynchronous, active-low reset.
- `St`  in  1: start request; sampled only in IDLE.
- `M`  in  1: accumulator bit 0, the current multiplier LSB.
- `Ack`  in  1: completion acknowledge; used only with `SHADD_ACK_EN` (see Configuration).
- `Load`  out  1: accumulator load strobe (clears the upper part, loads the multiplier).
- `Ad`  out  1: accumulator add strobe (captures the adder result into the upper part).
- `Sh`  out  1: accumulator right-shift strobe.
- `Done`  out  1: product valid in the accumulator.
- `Busy`  out  1: high in every state except IDLE.

## Operation
- Internal state:
  - FSM with states IDLE, LOAD, TEST, SHIFT, DONE.
  - Iteration counter `cnt` of width clog2(N).
- IDLE:
  - All strobes are 0.
  - `St`=1 → LOAD; otherwise stay in IDLE.
- LOAD:
  - `Load`=1; `cnt` ← 0.
  - Next state: TEST.
- TEST (strobes are a Mealy decode on `M`):
  - `M`=1: `Ad`=1, `Sh`=0, next state SHIFT; `cnt` unchanged.
  - `M`=0: `Sh`=1, `Ad`=0; `cnt` ← `cnt`+1.
    - If `cnt`==N-1, next state DONE; otherwise stay in TEST.
- SHIFT:
  - `Sh`=1; `cnt` ← `cnt`+1.
  - If `cnt`==N-1, next state DONE; otherwise TEST.
- DONE:
  - `Done`=1.
  - Next state: IDLE (behaviour with `SHADD_ACK_EN` is under Configuration).
- Strobe rules:
  - `Ad` and `Sh` are never high in the same cycle.
  - `Load` is never high together with `Ad` or `Sh`.
  - Exactly N `Sh` pulses per operation.
  - Exactly popcount(multiplier) `Ad` pulses per operation.
- Counter rules:
  - `cnt` never exceeds N-1.
  - `cnt` does not wrap during an operation.
  - `cnt` holds its value in IDLE and DONE.
- `St` while `Busy`=1 is ignored; no queuing, no restart.
- `M` is don't-care outside TEST.

## Timing
- Reset:
  - `Rst_n`=0 forces IDLE and `cnt`=0 immediately, without waiting for a clock edge.
  - All outputs read 0 while reset is held.
  - Reset asserted mid-operation aborts the operation. The accumulator contents are then undefined to the system, and a new `St` is required.
- Latency (edge E0 samples `St`=1 in IDLE):
  - `Load` is high in the cycle after E0.
  - TEST is entered at E1.
  - `Done` rises after edge E(1+N+k), where k = popcount(multiplier).
  - With N=4: minimum 5 edges, maximum 9 edges.
- Back-to-back operation:
  - Without the macro, `Done` lasts exactly one cycle.
  - IDLE follows, and `St` can be sampled on the very next edge.
- `Busy` is registered-state-derived and goes high one cycle after E0.

## Configuration
- `SHADD_ACK_EN` undefined:
  - DONE lasts one cycle and `Done` is a single-cycle pulse.
  - `Ack` is ignored.
- `SHADD_ACK_EN` defined:
  - DONE holds, with `Done`=1 and `Busy`=1, until `Ack`=1 is sampled in DONE; next state is then IDLE.
  - `Ack` in any other state is ignored.
  - `St` while in DONE is ignored.

## Test plan
- Reset mid-operation: assert `Rst_n`=0 while in SHIFT → all outputs 0 at once; after release, the FSM is in IDLE and `St` starts a clean operation.
- Multiplier 0b1011, multiplicand 0b1101, N=4:
  - Strobe sequence is Load, Ad, Sh, Ad, Sh, Sh, Ad, Sh.
  - `Done` rises after edge 8.
  - Accumulator reads 143 (0x08F).
- Multiplier 0b0000 → Load then four single `Sh` pulses, no `Ad`; `Done` after edge 5; product 0.
- Multiplier 0b1111 × 0b1111 → four Ad/Sh pairs; `Done` after edge 9; product 225.
- `St` pulsed repeatedly during the 0b1011 operation → no effect on the strobe sequence or the result; after `Done`, `St` on the next edge starts a new operation.
- With `SHADD_ACK_EN` defined: `Ack` withheld for 10 cycles → `Done` held for those 10 cycles; `Ack`=1 → IDLE on the next edge; `Ack` given during TEST has no effect.

Source files
------------

// File: rtl/shift_add_ctrl.sv
// Sequencer for the shift-add multiplier: drives the Load/Ad/Sh strobes of the accumulator from its LSB (M).
// Optional macro SHADD_ACK_EN holds DONE until Ack is sampled; when it is undefined, Done is a one-cycle pulse.
module shift_add_ctrl #(
  parameter int N = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic St,
  input  logic M,
  input  logic Ack,
  output logic Load,
  output logic Ad,
  output logic Sh,
  output logic Done,
  output logic Busy
);

  localparam int CW = $clog2(N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TEST  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

`ifndef SHADD_ACK_EN
  logic unused_ack;
  assign unused_ack = Ack;
`endif

  // The final shift leaves cnt at N-1 instead of stepping past it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    Load    = 1'b0;
    Ad      = 1'b0;
    Sh      = 1'b0;
    Done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (St) state_d = S_LOAD;
      end
      S_LOAD: begin
        Load    = 1'b1;
        cnt_d   = '0;
        state_d = S_TEST;
      end
      S_TEST: begin
        if (M) begin
          Ad      = 1'b1;
          state_d = S_SHIFT;
        end else begin
          Sh = 1'b1;
          if (cnt_last) state_d = S_DONE;
          else          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        Sh = 1'b1;
        if (cnt_last) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_TEST;
        end
      end
      S_DONE: begin
        Done = 1'b1;
`ifdef SHADD_ACK_EN
        if (Ack) state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy = (state_q != S_IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
